// File: rtl/inst_fetch_unit.sv
// Instruction fetch front-end: sequential PC generation, pipelined imem requests,
// in-order response buffering toward decode, with redirect flush and halt/drain control.
module inst_fetch_unit #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned       FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [DATA_W-1:0] imem_resp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted
);

  localparam int unsigned CNT_W  = $clog2(2 * FIFO_DEPTH) + 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_FETCH  = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0] fifo_cnt_q, fifo_cnt_d;

  logic [ADDR_W-1:0] pc_mem    [FIFO_DEPTH];
  logic [DATA_W-1:0] instr_mem [FIFO_DEPTH];

  logic              redirect_take;
  logic              req_fire;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  live_outstanding;
  logic [CNT_W-1:0]  credit_used;
  logic [ADDR_W-1:0] redirect_pc_aligned;

  // Buffer head and status, all derived from flops only
  always_comb begin
    out_valid = (fifo_cnt_q != '0);
    out_pc    = out_valid ? pc_mem[rd_ptr_q] : '0;
    out_instr = out_valid ? instr_mem[rd_ptr_q] : '0;
    halted    = (state_q == S_HALTED);
  end

  // Next-state, request issue and buffer bookkeeping
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fifo_cnt_d    = fifo_cnt_q;

    redirect_take       = redirect_valid && (state_q != S_BOOT);
    redirect_pc_aligned = {redirect_pc[ADDR_W-1:2], 2'b00};

    // Stale requests awaiting discard do not consume buffer credit
    live_outstanding = outstanding_q - drop_cnt_q;
    credit_used      = CNT_W'(fifo_cnt_q) + live_outstanding;

    imem_req_valid = (state_q == S_FETCH) && !halt && !redirect_valid &&
                     (credit_used < CNT_W'(FIFO_DEPTH));
    imem_req_addr  = fetch_pc_q;

    req_fire = imem_req_valid && imem_req_ready;
    push     = imem_resp_valid && (drop_cnt_q == '0) && !redirect_take;
    pop      = out_valid && out_ready && !redirect_take;

    outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);

    case (state_q)
      S_BOOT:   state_d = S_FETCH;
      S_FETCH:  if (halt && (outstanding_q == '0)) state_d = S_HALTED;
      S_HALTED: if (!halt) state_d = S_FETCH;
      default:  state_d = S_BOOT;
    endcase

    if (redirect_take) begin
      // A response landing in the redirect cycle belongs to the old stream
      drop_cnt_d = outstanding_q - CNT_W'(imem_resp_valid);
      fetch_pc_d = redirect_pc_aligned;
      resp_pc_d  = redirect_pc_aligned;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fifo_cnt_d = '0;
    end else begin
      if (imem_resp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CNT_W'(1);
      if (req_fire) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      if (push) begin
        resp_pc_d = resp_pc_q + ADDR_W'(4);
        wr_ptr_d  = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      fifo_cnt_d = fifo_cnt_q + FCNT_W'(push) - FCNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_BOOT;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
    end
  end

  // Entry storage needs no reset: fifo_cnt_q gates visibility
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= resp_pc_q;
      instr_mem[wr_ptr_q] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: fixed-latency memory model plus per-scenario
// tasks with hand-computed expected PCs, instructions and handshake timing.
module tb_inst_fetch_unit;

  localparam logic [31:0] K = 32'hA5A5A5A5;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;

  int n_total = 0;
  int n_bad   = 0;

  inst_fetch_unit #(
    .ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          c;
  } rec_t;

  mreq_t mq[$];
  rec_t  req_log[$];
  rec_t  pop_log[$];
  mreq_t m_tmp;
  rec_t  r_tmp;
  int    cyc = 0;
  int    lat = 1;

  // Fixed-latency in-order memory; also logs accepted requests and pops just before each edge
  always begin
    @(negedge clk);
    cyc++;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mq[0].addr ^ K;
      void'(mq.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
    #4;
    if (reset) begin
      if (imem_req_valid && imem_req_ready) begin
        m_tmp.addr = imem_req_addr;
        m_tmp.due  = cyc + lat;
        mq.push_back(m_tmp);
        r_tmp.a = imem_req_addr;
        r_tmp.d = 32'h0;
        r_tmp.c = cyc;
        req_log.push_back(r_tmp);
      end
      if (out_valid && out_ready && !redirect_valid) begin
        r_tmp.a = out_pc;
        r_tmp.d = out_instr;
        r_tmp.c = cyc;
        pop_log.push_back(r_tmp);
      end
    end
  end

  // Returns at the negedge where reset is released (DUT still in BOOT)
  task automatic apply_reset(input int l);
    @(negedge clk);
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt           = 1'b0;
    out_ready      = 1'b0;
    imem_req_ready = 1'b1;
    lat            = l;
    repeat (2) @(negedge clk);
    mq.delete();
    req_log.delete();
    pop_log.delete();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset          = 1'b0;
    imem_req_ready = 1'b0;
    repeat (3) @(negedge clk);
    #4;
    n_total++;
    if (out_valid !== 1'b0 || imem_req_valid !== 1'b0 || halted !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_flags: out_valid=%b req_valid=%b halted=%b want 0 0 0",
               out_valid, imem_req_valid, halted);
    end
    n_total++;
    if (imem_req_addr !== 32'h0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_values: addr=%h out_pc=%h out_instr=%h want all 0",
               imem_req_addr, out_pc, out_instr);
    end
    @(negedge clk);
    reset = 1'b1;
    #4;
    n_total++;
    if (imem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL boot_no_req: req_valid=%b want 0", imem_req_valid);
    end
    @(negedge clk);
    #4;
    n_total++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL first_req: req_valid=%b addr=%h want 1 00000000",
               imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_stream();
    apply_reset(1);
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    n_total++;
    if (pop_log.size() < 5) begin
      n_bad++;
      $display("FAIL stream_count: pops=%0d want >=5", pop_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_total++;
        if (pop_log[i].a !== 32'(4 * i) || pop_log[i].d !== (32'(4 * i) ^ K)) begin
          n_bad++;
          $display("FAIL stream_pop%0d: pc=%h instr=%h want %h %h",
                   i, pop_log[i].a, pop_log[i].d, 32'(4 * i), 32'(4 * i) ^ K);
        end
        n_total++;
        if (pop_log[i + 1].c - pop_log[i].c !== 1) begin
          n_bad++;
          $display("FAIL stream_rate%0d: gap=%0d want 1", i, pop_log[i + 1].c - pop_log[i].c);
        end
      end
    end
    // Asynchronous reset while the buffer holds data
    @(negedge clk);
    #2;
    n_total++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL stream_prereset_valid: out_valid=%b want 1", out_valid);
    end
    reset = 1'b0;
    #1;
    n_total++;
    if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: out_valid=%b req_valid=%b want 0 0", out_valid, imem_req_valid);
    end
  endtask

  task automatic test_backpressure();
    apply_reset(1);
    repeat (10) @(negedge clk);
    n_total++;
    if (req_log.size() !== 4) begin
      n_bad++;
      $display("FAIL bp_req_count: reqs=%0d want 4", req_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_total++;
        if (req_log[i].a !== 32'(4 * i)) begin
          n_bad++;
          $display("FAIL bp_req%0d: addr=%h want %h", i, req_log[i].a, 32'(4 * i));
        end
      end
    end
    #4;
    n_total++;
    if (imem_req_valid !== 1'b0 || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_stall: req_valid=%b out_valid=%b want 0 1", imem_req_valid, out_valid);
    end
    @(negedge clk);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    n_total++;
    if (pop_log.size() < 1 || req_log.size() < 5) begin
      n_bad++;
      $display("FAIL bp_resume: pops=%0d reqs=%0d want >=1 >=5", pop_log.size(), req_log.size());
    end else begin
      n_total++;
      if (pop_log[0].a !== 32'h0 || pop_log[0].d !== (32'h0 ^ K)) begin
        n_bad++;
        $display("FAIL bp_first_pop: pc=%h instr=%h want 00000000 %h", pop_log[0].a, pop_log[0].d, K);
      end
      n_total++;
      if (req_log[4].a !== 32'h10 || req_log[4].c !== pop_log[0].c + 1) begin
        n_bad++;
        $display("FAIL bp_req_after_pop: addr=%h cyc=%0d want 00000010 cyc=%0d",
                 req_log[4].a, req_log[4].c, pop_log[0].c + 1);
      end
    end
  endtask

  task automatic test_redirect();
    bit found;
    apply_reset(3);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if (req_log.size() !== 2) begin
      n_bad++;
      $display("FAIL redir_inflight: reqs=%0d want 2", req_log.size());
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    #3;
    n_total++;
    if (imem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL redir_no_req: req_valid=%b want 0", imem_req_valid);
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (12) @(negedge clk);
    n_total++;
    if (req_log.size() < 3 || pop_log.size() < 2) begin
      n_bad++;
      $display("FAIL redir_progress: reqs=%0d pops=%0d want >=3 >=2", req_log.size(), pop_log.size());
    end else begin
      n_total++;
      if (req_log[2].a !== 32'h100) begin
        n_bad++;
        $display("FAIL redir_new_addr: addr=%h want 00000100", req_log[2].a);
      end
      n_total++;
      if (pop_log[0].a !== 32'h100 || pop_log[0].d !== (32'h100 ^ K) || pop_log[1].a !== 32'h104) begin
        n_bad++;
        $display("FAIL redir_pops: pc0=%h instr0=%h pc1=%h want 00000100 %h 00000104",
                 pop_log[0].a, pop_log[0].d, pop_log[1].a, 32'h100 ^ K);
      end
    end
    // Redirect coinciding with a response from the old stream
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (imem_resp_valid) begin
        found = 1'b1;
        break;
      end
    end
    n_total++;
    if (!found) begin
      n_bad++;
      $display("FAIL redir2_resp_wait: no response seen within 20 cycles");
    end
    pop_log.delete();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (12) @(negedge clk);
    n_total++;
    if (pop_log.size() < 2) begin
      n_bad++;
      $display("FAIL redir2_progress: pops=%0d want >=2", pop_log.size());
    end else begin
      n_total++;
      if (pop_log[0].a !== 32'h200 || pop_log[0].d !== (32'h200 ^ K) ||
          pop_log[1].a !== 32'h204 || pop_log[1].d !== (32'h204 ^ K)) begin
        n_bad++;
        $display("FAIL redir2_pops: pc0=%h instr0=%h pc1=%h instr1=%h want 00000200 %h 00000204 %h",
                 pop_log[0].a, pop_log[0].d, pop_log[1].a, pop_log[1].d,
                 32'h200 ^ K, 32'h204 ^ K);
      end
    end
  endtask

  task automatic test_halt();
    bit seen;
    apply_reset(3);
    repeat (3) @(negedge clk);
    halt = 1'b1;
    #4;
    n_total++;
    if (imem_req_valid !== 1'b0 || halted !== 1'b0) begin
      n_bad++;
      $display("FAIL halt_block: req_valid=%b halted=%b want 0 0", imem_req_valid, halted);
    end
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      #4;
      if (halted) begin
        seen = 1'b1;
        break;
      end
    end
    n_total++;
    if (!seen) begin
      n_bad++;
      $display("FAIL halt_enter: halted=%b after 15 cycles want 1", halted);
    end
    @(negedge clk);
    n_total++;
    if (req_log.size() !== 2 || halted !== 1'b1) begin
      n_bad++;
      $display("FAIL halt_drain: reqs=%0d halted=%b want 2 1", req_log.size(), halted);
    end
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    n_total++;
    if (pop_log.size() !== 2) begin
      n_bad++;
      $display("FAIL halt_pop_count: pops=%0d want 2", pop_log.size());
    end else begin
      n_total++;
      if (pop_log[0].a !== 32'h0 || pop_log[0].d !== (32'h0 ^ K) ||
          pop_log[1].a !== 32'h4 || pop_log[1].d !== (32'h4 ^ K)) begin
        n_bad++;
        $display("FAIL halt_pops: pc0=%h instr0=%h pc1=%h instr1=%h want 00000000 %h 00000004 %h",
                 pop_log[0].a, pop_log[0].d, pop_log[1].a, pop_log[1].d, K, 32'h4 ^ K);
      end
    end
    halt = 1'b0;
    #4;
    n_total++;
    if (halted !== 1'b1 || imem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL unhalt_same_cycle: halted=%b req_valid=%b want 1 0", halted, imem_req_valid);
    end
    @(negedge clk);
    #4;
    n_total++;
    if (halted !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin
      n_bad++;
      $display("FAIL unhalt_resume: halted=%b req_valid=%b addr=%h want 0 1 00000008",
               halted, imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_wrap();
    apply_reset(1);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    pop_log.delete();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (8) @(negedge clk);
    n_total++;
    if (pop_log.size() < 3) begin
      n_bad++;
      $display("FAIL wrap_progress: pops=%0d want >=3", pop_log.size());
    end else begin
      n_total++;
      if (pop_log[0].a !== 32'hFFFF_FFFC || pop_log[0].d !== 32'h5A5A_5A59) begin
        n_bad++;
        $display("FAIL wrap_pop0: pc=%h instr=%h want fffffffc 5a5a5a59", pop_log[0].a, pop_log[0].d);
      end
      n_total++;
      if (pop_log[1].a !== 32'h0 || pop_log[1].d !== K || pop_log[2].a !== 32'h4) begin
        n_bad++;
        $display("FAIL wrap_pop1: pc1=%h instr1=%h pc2=%h want 00000000 %h 00000004",
                 pop_log[1].a, pop_log[1].d, pop_log[2].a, K);
      end
    end
  endtask

  initial begin
    reset           = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    halt            = 1'b0;
    out_ready       = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction fetch front-end that sits directly upstream of the CPU core's decode stage.
- Generates sequential fetch addresses and issues pipelined requests to instruction memory.
- Buffers in-order responses in a small FIFO and hands {pc, instr} to decode over a valid/ready handshake.
- Supports branch/jump redirect with discard of in-flight stale responses, plus a halt/drain control.

Parameters:
ADDR_W, 32, fetch address / PC width
DATA_W, 32, instruction word width
RESET_PC, 32'h0000_0000, first fetch address after reset
FIFO_DEPTH, 4, instruction buffer entries (power of 2, >=2); also the live-request credit limit

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  ADDR_W  word-aligned fetch address
imem_resp_valid  in  1  response data valid (in order, any latency >=1, no backpressure)
imem_resp_data  in  DATA_W  instruction word
redirect_valid  in  1  one-cycle pulse: flush and restart fetch
redirect_pc  in  ADDR_W  new fetch address; bits [1:0] ignored (treated as 0)
halt  in  1  level: stop issuing new requests
out_valid  out  1  buffered instruction available
out_ready  in  1  decode consumes head entry
out_instr  out  DATA_W  head instruction
out_pc  out  ADDR_W  PC of head instruction
halted  out  1  FSM in HALTED

Behaviour:
- Reset (reset=0, asynchronous):
  - fetch_pc=RESET_PC, resp_pc=RESET_PC.
  - FIFO empty, outstanding=0, drop_cnt=0, state=BOOT.
  - All outputs 0 except imem_req_addr=RESET_PC.
  - Reset asserted mid-operation discards everything; responses to pre-reset requests are not tracked (memory is reset with the core).
- FSM:
  - BOOT -> FETCH after one cycle.
  - FETCH -> HALTED when halt=1 and outstanding=0.
  - HALTED -> FETCH the cycle after halt=0.
  - In FETCH with halt=1, outstanding requests drain before the move to HALTED.
- Request issue:
  - imem_req_valid = (state==FETCH) & ~halt & ~redirect_valid & (fifo_count + live_outstanding < FIFO_DEPTH).
  - live_outstanding = outstanding - drop_cnt.
  - imem_req_addr = fetch_pc.
  - On handshake: fetch_pc += 4 (wraps modulo 2^ADDR_W); outstanding += 1.
  - imem_req_valid may deassert without a handshake (redirect, halt).
- Response:
  - Every imem_resp_valid decrements outstanding.
  - If drop_cnt>0: response is discarded and drop_cnt -= 1.
  - Otherwise: push {resp_pc, data} into FIFO and resp_pc += 4. FIFO cannot overflow by the credit rule.
- Output:
  - out_valid = FIFO non-empty; out_pc/out_instr show the head entry.
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle are both honored.
  - Response-to-out_valid latency is 1 cycle (no bypass).
- Redirect (highest priority, accepted in any state except BOOT):
  - FIFO cleared; any pop that cycle is void.
  - fetch_pc and resp_pc <= {redirect_pc[ADDR_W-1:2],2'b00}.
  - drop_cnt <= outstanding - imem_resp_valid. A response arriving in the redirect cycle is always discarded.
  - No request is issued in the redirect cycle. Requests for the new stream may issue the next cycle while stale responses drain.
  - Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
- Counter widths:
  - outstanding and drop_cnt: $clog2(2*FIFO_DEPTH)+1 bits.
  - outstanding never exceeds 2*FIFO_DEPTH.
- halted = (state==HALTED). In HALTED, the FIFO still drains to decode and redirect still updates the PCs.

Test Plan:
- Reset/boot: hold reset=0 for 3 cycles, release -> cycle 1 BOOT with no request; cycle 2 imem_req_valid=1, addr=0x0. Assert reset=0 mid-stream -> out_valid=0 immediately.
- Streaming: 1-cycle memory returning data=addr^0xA5A5A5A5, out_ready=1 -> out_pc sequence 0x0,0x4,0x8,0xC, one instruction per cycle sustained, instr values match.
- Backpressure: out_ready=0 -> exactly 4 requests issued (0x0..0xC), then imem_req_valid=0. Raise out_ready -> pops 0x0, and request 0x10 issues the cycle after the first pop.
- Redirect with stale data: 3-cycle memory, 2 requests in flight, redirect_pc=0x103 -> next request addr=0x100; both stale responses dropped; first out_pc=0x100. Repeat with a response arriving in the redirect cycle -> also dropped.
- Halt: assert halt with 2 outstanding -> no new requests; halted=1 after the 2nd response. The buffered 2 entries still pop. Deassert halt -> FETCH next cycle, request resumes at next sequential address.
- Wrap: redirect_pc=0xFFFFFFFC -> out_pc 0xFFFFFFFC then 0x00000000.
